// File: rtl/scan_pkg.sv
// Shared types and constants for the HUB75 LED matrix scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int COLS_DEFAULT = 32;
  localparam int ROWS_DEFAULT = 16;

  // Frame-buffer address is {row, col}.
  localparam int COL_W   = 5;
  localparam int ROW_W   = 4;
  localparam int ADR_W   = ROW_W + COL_W;
  localparam int PIX_W   = 6;
  localparam int DWELL_W = 16;

  // rd[5:3] = {R,G,B} of upper panel half, rd[2:0] = {R,G,B} of lower half.
  localparam int TOP_RGB_HI = 5;
  localparam int BOT_RGB_HI = 2;

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter that times how long a row stays lit.
// Latency: load takes effect on the next clk edge; o_done is combinational on the count.
// Backpressure: none; counts only while i_dec is high and stops at zero.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   i_load/i_load_val load the counter (load wins over decrement)
//   i_dec             decrement enable
//   o_done            count has reached zero
module scan_dwell_timer
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_done
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Walks the 512x6 frame buffer and drives a 32x32 HUB75 panel at 1/16 scan.
// Latency: one-column address prefetch; each row takes 67 + ON_CYCLES clk cycles.
// Backpressure: none; free-running while en is high, en sampled only in IDLE and at row end.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   en                  scan enable
//   rd[5:0]             pixel pair read from the frame buffer
//   adr[8:0]            frame-buffer read address {row, col}
//   r1,g1,b1,r2,g2,b2   panel colour data (upper / lower half)
//   sclk, lat, oe_n     panel shift clock, latch strobe, output enable (active low)
//   row_sel[3:0]        panel row address A..D
//   frame_start         one-cycle pulse in the row-0 PREFETCH cycle
// Build option: define SCAN_FRAME_PULSE_EN to generate frame_start; otherwise it is tied low.
module led_matrix_scan
  import scan_pkg::*;
#(
  parameter int ON_CYCLES = 256,
  parameter int COLS      = COLS_DEFAULT,
  parameter int ROWS      = ROWS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [PIX_W-1:0] rd,
  output logic [ADR_W-1:0] adr,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  output logic             r2,
  output logic             g2,
  output logic             b2,
  output logic             sclk,
  output logic             lat,
  output logic             oe_n,
  output logic [ROW_W-1:0] row_sel,
  output logic             frame_start
);

  localparam logic [COL_W-1:0]   LP_LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LP_LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [DWELL_W-1:0] LP_DWELL_LOAD = DWELL_W'(ON_CYCLES - 1);

  scan_state_t      r_state, w_state_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             r_ph, w_ph_nxt;
  logic [ADR_W-1:0] r_adr, w_adr_nxt;
  logic [PIX_W-1:0] r_rgb, w_rgb_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_lat, w_lat_nxt;
  logic             r_oe_n, w_oe_n_nxt;
  logic [ROW_W-1:0] r_row_sel, w_row_sel_nxt;
  logic             w_dwell_load;
  logic             w_dwell_done;
  logic [COL_W-1:0] w_col_inc;
  logic [ROW_W-1:0] w_row_inc;

  assign w_col_inc = r_col + COL_W'(1);
  assign w_row_inc = (r_row == LP_LAST_ROW) ? '0 : r_row + ROW_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_ph      <= 1'b0;
      r_adr     <= '0;
      r_rgb     <= '0;
      r_sclk    <= 1'b0;
      r_lat     <= 1'b0;
      r_oe_n    <= 1'b1;
      r_row_sel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_ph      <= w_ph_nxt;
      r_adr     <= w_adr_nxt;
      r_rgb     <= w_rgb_nxt;
      r_sclk    <= w_sclk_nxt;
      r_lat     <= w_lat_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_row_sel <= w_row_sel_nxt;
    end
  end

  // Outputs are registered: this block computes the value each output takes
  // on entry to the next state, so every output is valid for its whole state.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_ph_nxt      = r_ph;
    w_adr_nxt     = r_adr;
    w_rgb_nxt     = r_rgb;
    w_sclk_nxt    = r_sclk;
    w_lat_nxt     = r_lat;
    w_oe_n_nxt    = r_oe_n;
    w_row_sel_nxt = r_row_sel;
    w_dwell_load  = 1'b0;

    case (r_state)
      IDLE: begin
        w_oe_n_nxt = 1'b1;
        if (en) begin
          w_state_nxt = PREFETCH;
          w_adr_nxt   = {r_row, COL_W'(0)};
        end
      end

      PREFETCH: begin
        // rd now holds column 0; present it and fetch column 1.
        w_state_nxt = SHIFT;
        w_col_nxt   = '0;
        w_ph_nxt    = 1'b0;
        w_rgb_nxt   = rd;
        w_adr_nxt   = {r_row, COL_W'(1)};
        w_sclk_nxt  = 1'b0;
      end

      SHIFT: begin
        if (!r_ph) begin
          w_ph_nxt   = 1'b1;
          w_sclk_nxt = 1'b1;
        end else if (r_col == LP_LAST_COL) begin
          w_state_nxt = BLANK;
          w_col_nxt   = '0;
          w_ph_nxt    = 1'b0;
          w_sclk_nxt  = 1'b0;
        end else begin
          // Data for column c+1 arrives while the address for c+2 goes out;
          // the address past the last column wraps and is never used.
          w_col_nxt  = w_col_inc;
          w_ph_nxt   = 1'b0;
          w_rgb_nxt  = rd;
          w_adr_nxt  = {r_row, w_col_inc + COL_W'(1)};
          w_sclk_nxt = 1'b0;
        end
      end

      BLANK: begin
        w_state_nxt   = LATCH;
        w_lat_nxt     = 1'b1;
        w_row_sel_nxt = r_row;
        w_oe_n_nxt    = 1'b1;
        w_sclk_nxt    = 1'b0;
      end

      LATCH: begin
        w_state_nxt  = DISPLAY;
        w_lat_nxt    = 1'b0;
        w_oe_n_nxt   = 1'b0;
        w_dwell_load = 1'b1;
      end

      DISPLAY: begin
        if (w_dwell_done) begin
          w_row_nxt  = w_row_inc;
          w_oe_n_nxt = 1'b1;
          if (en) begin
            w_state_nxt = PREFETCH;
            w_adr_nxt   = {w_row_inc, COL_W'(0)};
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_oe_n_nxt  = 1'b1;
      end
    endcase
  end

  scan_dwell_timer u_dwell (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_dwell_load),
    .i_load_val (LP_DWELL_LOAD),
    .i_dec      (r_state == DISPLAY),
    .o_done     (w_dwell_done)
  );

`ifdef SCAN_FRAME_PULSE_EN
  logic r_frame_start;

  // PREFETCH lasts one cycle, so this is high exactly for the row-0 PREFETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= (w_state_nxt == PREFETCH) && (w_row_nxt == '0);
    end
  end

  assign frame_start = r_frame_start;
`else
  assign frame_start = 1'b0;
`endif

  assign adr     = r_adr;
  assign r1      = r_rgb[TOP_RGB_HI];
  assign g1      = r_rgb[TOP_RGB_HI-1];
  assign b1      = r_rgb[TOP_RGB_HI-2];
  assign r2      = r_rgb[BOT_RGB_HI];
  assign g2      = r_rgb[BOT_RGB_HI-1];
  assign b2      = r_rgb[BOT_RGB_HI-2];
  assign sclk    = r_sclk;
  assign lat     = r_lat;
  assign oe_n    = r_oe_n;
  assign row_sel = r_row_sel;

endmodule
